axi4_burst_master: RTL

AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

---
 rtl/axi4_burst_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 burst master.
// Accepts one command (direction, start address, AXI LEN) on a valid/ready
// port, issues the AW/AR request, streams write beats from wr_* or read beats
// to rd_*, and reports completion with a one-cycle done pulse plus resp.
// Ports:
//   ACLK, ARESTN                   clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/len command request
//   wr_data/wr_valid/wr_ready      write beat stream in
//   rd_data/rd_valid               read beat stream out (no backpressure)
//   done, resp                     completion pulse and final response
//   AW*/W*/B*/AR*/R*               AXI4 master channels
module axi4_burst_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESTN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic [1:0]            resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [2:0] AXSIZE   = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [7:0] CNT_MAX  = 8'hFF;
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WADDR, WDATA_S, WRESP, RADDR, RDATA_S
  } state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_count;
  logic [1:0]            r_resp;
  logic                  r_done, r_cmd_ready;
  logic                  r_awvalid, r_arvalid, r_bready, r_rready;
  logic                  w_accept, w_in_wdata, w_in_rdata, w_wbeat, w_rlast_err;

  assign w_accept    = cmd_valid && r_cmd_ready;
  assign w_in_wdata  = (r_state == WDATA_S);
  assign w_in_rdata  = (r_state == RDATA_S);
  assign w_wbeat     = w_in_wdata && wr_valid && WREADY;
  // Beat-count vs RLAST disagreement in either direction is a protocol error.
  assign w_rlast_err = (RLAST && (r_count != r_len)) || (!RLAST && (r_count == r_len));

  // Write-data and read-data paths are pure pass-through gated by state.
  assign WDATA    = wr_data;
  assign WVALID   = w_in_wdata && wr_valid;
  assign wr_ready = w_in_wdata && WREADY;
  assign WLAST    = WVALID && (r_count == r_len);
  assign rd_data  = RDATA;
  assign rd_valid = w_in_rdata && RVALID;

  assign cmd_ready = r_cmd_ready;
  assign done      = r_done;
  assign resp      = r_resp;
  assign AWADDR    = r_addr;
  assign AWLEN     = r_len;
  assign AWSIZE    = AXSIZE;
  assign AWVALID   = r_awvalid;
  assign BREADY    = r_bready;
  assign ARADDR    = r_addr;
  assign ARLEN     = r_len;
  assign ARSIZE    = AXSIZE;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;

  // State register.
  always_ff @(posedge ACLK) begin
    if (!ARESTN) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = cmd_write ? WADDR : RADDR;
      WADDR:   if (AWREADY) w_next = WDATA_S;
      WDATA_S: if (w_wbeat && (r_count == r_len)) w_next = WRESP;
      WRESP:   if (BVALID) w_next = IDLE;
      RADDR:   if (ARREADY) w_next = RDATA_S;
      RDATA_S: if (RVALID && RLAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered channel controls, beat counter and response tracking.
  always_ff @(posedge ACLK) begin
    if (!ARESTN) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_count     <= '0;
      r_resp      <= RESP_OK;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      // Control outputs are decoded from the next state so they align with it.
      r_done      <= (r_state != IDLE) && (w_next == IDLE);
      r_cmd_ready <= (w_next == IDLE);
      r_awvalid   <= (w_next == WADDR);
      r_arvalid   <= (w_next == RADDR);
      r_bready    <= (w_next == WRESP);
      r_rready    <= (w_next == RDATA_S);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= cmd_addr;
            r_len   <= cmd_len;
            r_count <= '0;
            r_resp  <= RESP_OK;
          end
        end
        WADDR:   if (AWREADY) r_count <= '0;
        WDATA_S: if (w_wbeat && (r_count != CNT_MAX)) r_count <= r_count + 8'd1;
        WRESP:   if (BVALID) r_resp <= BRESP;
        RADDR:   if (ARREADY) r_count <= '0;
        RDATA_S: begin
          if (RVALID) begin
            if (r_count != CNT_MAX) r_count <= r_count + 8'd1;
            // resp == OKAY doubles as "no error recorded yet" since it is
            // cleared on acceptance.
            if (w_rlast_err)                             r_resp <= RESP_ERR;
            else if ((r_resp == RESP_OK) && (RRESP != RESP_OK)) r_resp <= RRESP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
